// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipe
//  Brief    : Pipelined WIDTH-bit add/subtract unit. The operation is split
//             into WIDTH/CHUNK carry-chained slices, one slice per stage,
//             behind a valid/ready handshake with full-pipeline backpressure.
//             Produces carry, signed overflow, zero and negative flags.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Pipeline-wide enable: the whole pipe moves whenever the output register
  // is empty or is being consumed this cycle.
  logic advance;

  // Stage registers. Stage k holds the operation after slice k was added.
  // Operands travel along so later stages can add their upper slices; the
  // partial sum carries the already-computed lower slices.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // Flags are produced alongside the final slice and registered with it.
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Inputs seen by each stage: stage 0 takes the ports, stage k takes the
  // registers of stage k-1.
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];

  // CHUNK-bit slice sum plus its carry out, one per stage.
  logic [CHUNK:0]    slice_sum [STAGES];

  logic [WIDTH-1:0]  final_sum;

  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  // Route each stage's operands: ports into stage 0, previous stage onward.
  always_comb begin
    src_valid    = '0;
    src_carry    = '0;
    src_a        = '{default: '0};
    src_b        = '{default: '0};
    src_sum      = '{default: '0};
    src_valid[0] = in_valid;
    src_carry[0] = c_in;
    src_a[0]     = a;
    src_b[0]     = b ^ {WIDTH{op}};
    src_sum[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
    end
  end

  // Add one CHUNK-wide slice per stage and merge it into the partial sum.
  always_comb begin
    valid_d   = '0;
    carry_d   = '0;
    a_d       = '{default: '0};
    b_d       = '{default: '0};
    sum_d     = '{default: '0};
    slice_sum = '{default: '0};
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_carry[k]};
      valid_d[k]   = src_valid[k];
      carry_d[k]   = slice_sum[k][CHUNK];
      a_d[k]       = src_a[k];
      b_d[k]       = src_b[k];
      sum_d[k]     = src_sum[k];
      sum_d[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
    end
  end

  // Flags from the complete result leaving the last slice adder. Overflow:
  // operands of equal sign producing a result of the other sign.
  always_comb begin
    final_sum = sum_d[LAST];
    ovf_d     = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                (final_sum[WIDTH-1] != src_a[LAST][WIDTH-1]);
    zero_d    = (final_sum == '0);
    neg_d     = final_sum[WIDTH-1];
  end

  // Pipeline registers: cleared by reset, shifted together on advance,
  // held as a whole otherwise so outputs stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sum_q   <= '{default: '0};
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign s         = sum_q[LAST];
  assign c_out     = carry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule
`default_nettype wire
